// File: rtl/dac_stream_pkg.sv
// dac_stream_pkg: shared types and helpers for the DAC stream arbiter
package dac_stream_pkg;
  localparam int DAC_BATCH_WIDTH = 256;
  typedef logic [DAC_BATCH_WIDTH-1:0] dac_batch_t;
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  function automatic state_t grant_state(input logic g);
    return g ? GRANT1 : GRANT0;
  endfunction
endpackage

// File: rtl/rr_grant_sel.sv
// rr_grant_sel: 2-way round-robin picker, favours the source that was not served last
module rr_grant_sel (
  input  logic i_v0,
  input  logic i_v1,
  input  logic i_last,
  output logic o_any,
  output logic o_sel
);
  assign o_any = i_v0 | i_v1;
  assign o_sel = (i_v0 & i_v1) ? ~i_last : i_v1;
endmodule

// File: rtl/dac_stream_arbiter.sv
// dac_stream_arbiter: burst-granular round-robin share of the DAC AXI-stream output
module dac_stream_arbiter
  import dac_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DAC_BATCH_WIDTH,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  m_axis_aclk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  s0_tvalid,
  output logic                  s0_tready,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic                  s0_tlast,
  input  logic                  s1_tvalid,
  output logic                  s1_tready,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic                  s1_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  dacDomain_batch_valid,
  output logic                  grant_id,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  batch_count
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  state_t r_state, w_nxt;
  logic r_grant, r_last;
  logic [BW-1:0] r_beat;
  logic [CNT_WIDTH-1:0] r_count;
  logic w_g0, w_g1, w_beat, w_end, w_any, w_sel;
  assign w_g0 = r_state == GRANT0;
  assign w_g1 = r_state == GRANT1;
  assign busy = w_g0 | w_g1;
  assign grant_id = r_grant;
  assign batch_count = r_count;
  assign s0_tready = w_g0 & m_tready;
  assign s1_tready = w_g1 & m_tready;
  assign m_tvalid = (w_g0 & s0_tvalid) | (w_g1 & s1_tvalid);
  assign m_tdata = w_g0 ? s0_tdata : w_g1 ? s1_tdata : '0;
  assign m_tlast = (w_g0 & s0_tlast) | (w_g1 & s1_tlast) | (busy & (r_beat == LAST_BEAT));
  assign w_beat = m_tvalid & m_tready;
  assign w_end = w_beat & m_tlast;
  assign dacDomain_batch_valid = w_beat;
  rr_grant_sel u_sel (
    .i_v0  (s0_tvalid),
    .i_v1  (s1_tvalid),
    .i_last(busy ? r_grant : r_last),
    .o_any (w_any),
    .o_sel (w_sel)
  );
  // re-arbitrate only from IDLE or at a burst end; otherwise hold the grant
  always_comb begin
    w_nxt = (!busy | w_end) ? ((enable & w_any) ? grant_state(w_sel) : IDLE) : r_state;
  end
  // grant state, burst beat counter, last-served source and delivered-batch counter
  always_ff @(posedge m_axis_aclk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_beat  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_nxt;
      r_grant <= w_nxt == GRANT1;
      if (w_end) begin
        r_last <= r_grant;
        r_beat <= '0;
      end else if (w_beat) r_beat <= r_beat + 1'b1;
      if (w_beat) r_count <= r_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_dac_stream_arbiter.sv
// tb_dac_stream_arbiter: directed self-checking bench for dac_stream_arbiter
module tb_dac_stream_arbiter;
  logic clk = 0, rst = 1, enable = 0, m_tready = 0;
  logic s0_tvalid = 0, s0_tlast = 0, s1_tvalid = 0, s1_tlast = 0;
  logic [255:0] s0_tdata = '0, s1_tdata = '0;
  logic s0_tready, s1_tready, m_tvalid, m_tlast, dbv, grant_id, busy;
  logic [255:0] m_tdata;
  logic [31:0] batch_count;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  dac_stream_arbiter dut (
    .m_axis_aclk(clk), .rst(rst), .enable(enable),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata), .s0_tlast(s0_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata), .s1_tlast(s1_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .dacDomain_batch_valid(dbv), .grant_id(grant_id), .busy(busy), .batch_count(batch_count)
  );
  function automatic logic [255:0] mkd(input int s, input int k);
    return {8'(s), 216'h0, 32'(k)};
  endfunction
  task automatic chk(input string t, input logic [255:0] o, input logic [255:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic exp_out(input string t, input logic v, input logic l, input logic [255:0] d,
                         input logic g, input logic b);
    chk({t, ".m_tvalid"}, m_tvalid, v);
    chk({t, ".m_tlast"}, m_tlast, l);
    chk({t, ".m_tdata"}, m_tdata, d);
    chk({t, ".grant_id"}, grant_id, g);
    chk({t, ".busy"}, busy, b);
    chk({t, ".batch_valid"}, dbv, v & m_tready);
  endtask
  task automatic exp_idle(input string t, input logic [31:0] cnt);
    exp_out(t, 0, 0, '0, 0, 0);
    chk({t, ".s0_tready"}, s0_tready, 0);
    chk({t, ".s1_tready"}, s1_tready, 0);
    chk({t, ".batch_count"}, batch_count, cnt);
  endtask
  initial begin
    enable = 1; m_tready = 1;
    tick(); tick();
    exp_idle("reset", 0);
    rst = 0;
    // 3-beat s0 burst; enable dropped on the final beat so the burst end returns to IDLE
    s0_tvalid = 1; s0_tdata = mkd(0, 1); #1;
    exp_idle("t1.bubble", 0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      s0_tdata = mkd(0, k); s0_tlast = k == 3; enable = k != 3; #1;
      exp_out($sformatf("t1.beat%0d", k), 1, k == 3, mkd(0, k), 0, 1);
      chk($sformatf("t1.s0_tready%0d", k), s0_tready, 1);
      tick();
    end
    s0_tvalid = 0; s0_tlast = 0; enable = 1; #1;
    exp_idle("t1.done", 3);
    // both sources always valid with 2-beat bursts: 0,0,1,1,0,0 with no bubble at switches
    rst = 1; tick(); rst = 0;
    exp_idle("t2.reset", 0);
    s0_tvalid = 1; s1_tvalid = 1; #1;
    exp_idle("t2.bubble", 0);
    tick();
    for (int k = 0; k < 6; k++) begin
      logic g;
      g = (k / 2) % 2 == 1;
      s0_tdata = mkd(0, k); s1_tdata = mkd(1, k);
      s0_tlast = k % 2 == 1; s1_tlast = k % 2 == 1; enable = k != 5; #1;
      exp_out($sformatf("t2.beat%0d", k), 1, k % 2 == 1, g ? mkd(1, k) : mkd(0, k), g, 1);
      tick();
    end
    s0_tvalid = 0; s1_tvalid = 0; s0_tlast = 0; s1_tlast = 0; enable = 1; #1;
    exp_idle("t2.done", 6);
    // s1 streams 40 beats without tlast: forced ends on 16 and 32, regranted without bubble
    s1_tvalid = 1; #1;
    exp_idle("t3.bubble", 6);
    tick();
    for (int k = 1; k <= 40; k++) begin
      s1_tdata = mkd(1, k); #1;
      exp_out($sformatf("t3.beat%0d", k), 1, k % 16 == 0, mkd(1, k), 1, 1);
      tick();
    end
    s1_tvalid = 0; #1;
    chk("t3.still_busy", busy, 1);
    chk("t3.count", batch_count, 46);
    chk("t3.m_tlast_mid", m_tlast, 0);
    rst = 1; tick(); rst = 0;
    exp_idle("t4.reset", 0);
    // m_tready toggling during an s0 burst while s1 waits
    s0_tvalid = 1; s1_tvalid = 1; s0_tdata = mkd(0, 1); #1;
    exp_idle("t4.bubble", 0);
    tick();
    m_tready = 1; #1;
    exp_out("t4.c1", 1, 0, mkd(0, 1), 0, 1);
    chk("t4.c1.s0_tready", s0_tready, 1);
    chk("t4.c1.s1_tready", s1_tready, 0);
    tick();
    m_tready = 0; s0_tdata = mkd(0, 2); s0_tlast = 1; #1;
    exp_out("t4.c2", 1, 1, mkd(0, 2), 0, 1);
    chk("t4.c2.s0_tready", s0_tready, 0);
    chk("t4.c2.s1_tready", s1_tready, 0);
    tick();
    m_tready = 1; enable = 0; #1;
    exp_out("t4.c3", 1, 1, mkd(0, 2), 0, 1);
    chk("t4.c3.s0_tready", s0_tready, 1);
    chk("t4.c3.s1_tready", s1_tready, 0);
    tick();
    m_tready = 0; s0_tvalid = 0; s0_tlast = 0; s1_tvalid = 0; #1;
    exp_idle("t4.done", 2);
    m_tready = 1;
    // enable dropped mid-burst: s0 completes its 4 beats, s1 waits for enable
    enable = 1; s0_tvalid = 1; s0_tdata = mkd(0, 1); #1;
    exp_idle("t5.bubble", 2);
    tick();
    for (int k = 1; k <= 4; k++) begin
      s1_tvalid = 1; enable = k == 1; s0_tdata = mkd(0, k); s0_tlast = k == 4; #1;
      exp_out($sformatf("t5.beat%0d", k), 1, k == 4, mkd(0, k), 0, 1);
      chk($sformatf("t5.s1_tready%0d", k), s1_tready, 0);
      tick();
    end
    s0_tvalid = 0; s0_tlast = 0; s1_tdata = mkd(1, 1); #1;
    exp_idle("t5.idle0", 6);
    tick();
    exp_idle("t5.idle1", 6);
    enable = 1;
    tick();
    exp_out("t5.s1_granted", 1, 0, mkd(1, 1), 1, 1);
    chk("t5.s1_tready", s1_tready, 1);
    tick();
    // reset on beat 2 of the s1 burst drops the grant immediately
    s1_tdata = mkd(1, 2); rst = 1; #1;
    chk("t6.pre_count", batch_count, 7);
    tick();
    s0_tvalid = 1; s0_tdata = mkd(0, 9); #1;
    exp_idle("t6.reset", 0);
    rst = 0;
    tick();
    exp_out("t6.tie", 1, 0, mkd(0, 9), 0, 1);
    chk("t6.s1_tready", s1_tready, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
